// File: rtl/irq_entry_ctrl.sv
// rtl/irq_entry_ctrl.sv - interrupt entry sequencer in front of the register group
//
// Accepts a level interrupt request, freezes fetch, waits for writebacks to
// drain, then issues a one-cycle entry strobe with vector and resume PCs.
//
// Optional build macro: IRQ_DRAIN_TIMEOUT_EN (bounded drain, sticky irq_fault).
//
// Ports:
//   clk            system clock, rising edge
//   all_rst_n      synchronous active-low reset
//   irq_req        level interrupt request (sampled only in IDLE)
//   irq_num[7:0]   interrupt number, sampled with irq_req
//   sys_int_en     global interrupt enable from the sys register
//   resume_pc[31:0] oldest uncommitted instruction address
//   pipe_busy      high while a writeback is still pending
//   pc_stop        freezes pc update (HOLD, DRAIN, ENTER)
//   flush          kills fetched, non-committed instructions (HOLD, SETTLE)
//   interrupt_ask  one-cycle entry strobe (ENTER)
//   interrupt_pc   vector address during ENTER, else 0
//   interrupt_ipc  latched resume address during ENTER, else 0
//   irq_ack        one-cycle acknowledge to the source (ENTER)
//   irq_fault      sticky drain-timeout flag (0 unless timeout is built)

module irq_entry_ctrl #(
  parameter logic [31:0] VEC_BASE    = 32'h00000100,
  parameter int          DRAIN_LIMIT = 64
) (
  input  logic        clk,
  input  logic        all_rst_n,
  input  logic        irq_req,
  input  logic [7:0]  irq_num,
  input  logic        sys_int_en,
  input  logic [31:0] resume_pc,
  input  logic        pipe_busy,
  output logic        pc_stop,
  output logic        flush,
  output logic        interrupt_ask,
  output logic [31:0] interrupt_pc,
  output logic [31:0] interrupt_ipc,
  output logic        irq_ack,
  output logic        irq_fault
);

  if (DRAIN_LIMIT < 1) begin : g_bad_limit
    $error("DRAIN_LIMIT must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    DRAIN  = 3'd2,
    ENTER  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  num_q, num_d;
  logic [31:0] ipc_q, ipc_d;

`ifdef IRQ_DRAIN_TIMEOUT_EN
  localparam int CW = $clog2(DRAIN_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic          drain_expired;

  // The count is of DRAIN cycles already completed; this cycle is the last allowed one.
  assign drain_expired = pipe_busy && (cnt_q == CW'(DRAIN_LIMIT - 1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!all_rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      ipc_q   <= '0;
`ifdef IRQ_DRAIN_TIMEOUT_EN
      cnt_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      ipc_q   <= ipc_d;
`ifdef IRQ_DRAIN_TIMEOUT_EN
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
`endif
    end
  end

  // Next-state and capture logic; request inputs only matter in IDLE.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    ipc_d   = ipc_q;
`ifdef IRQ_DRAIN_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (irq_req && sys_int_en) begin
          num_d   = irq_num;
          ipc_d   = resume_pc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        state_d = DRAIN;
`ifdef IRQ_DRAIN_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      DRAIN: begin
`ifdef IRQ_DRAIN_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
        if (!pipe_busy) begin
          state_d = ENTER;
        end else if (drain_expired) begin
          state_d = ENTER;
          fault_d = 1'b1;
        end
`else
        if (!pipe_busy) begin
          state_d = ENTER;
        end
`endif
      end
      ENTER:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    pc_stop       = 1'b0;
    flush         = 1'b0;
    interrupt_ask = 1'b0;
    irq_ack       = 1'b0;
    interrupt_pc  = '0;
    interrupt_ipc = '0;
    case (state_q)
      HOLD: begin
        pc_stop = 1'b1;
        flush   = 1'b1;
      end
      DRAIN: pc_stop = 1'b1;
      ENTER: begin
        pc_stop       = 1'b1;
        interrupt_ask = 1'b1;
        irq_ack       = 1'b1;
        // Vector table entries are 4 bytes; the sum wraps modulo 2^32.
        interrupt_pc  = VEC_BASE + {22'b0, num_q, 2'b00};
        interrupt_ipc = ipc_q;
      end
      SETTLE:  flush = 1'b1;
      default: ;
    endcase
  end

`ifdef IRQ_DRAIN_TIMEOUT_EN
  assign irq_fault = fault_q;
`else
  assign irq_fault = 1'b0;
`endif

endmodule

// File: tb/tb_irq_entry_ctrl.sv
// tb/tb_irq_entry_ctrl.sv - self-checking bench for irq_entry_ctrl
module tb_irq_entry_ctrl;

  localparam logic [31:0] BASE_A = 32'h00000100;
  localparam logic [31:0] BASE_W = 32'hFFFFFF00;
  localparam int          LIM_A  = 64;
  localparam int          LIM_T  = 4;

  logic        clk = 1'b0;
  logic        all_rst_n, irq_req, sys_int_en, pipe_busy;
  logic [7:0]  irq_num;
  logic [31:0] resume_pc;

  logic        a_stop, a_flush, a_ask, a_ack, a_fault;
  logic [31:0] a_pc, a_ipc;
  logic        w_stop, w_flush, w_ask, w_ack, w_fault;
  logic [31:0] w_pc, w_ipc;
  logic        t_stop, t_flush, t_ask, t_ack, t_fault;
  logic [31:0] t_pc, t_ipc;

  always #5 clk = ~clk;

  irq_entry_ctrl #(.VEC_BASE(BASE_A), .DRAIN_LIMIT(LIM_A)) dut_a (
    .clk(clk), .all_rst_n(all_rst_n), .irq_req(irq_req), .irq_num(irq_num),
    .sys_int_en(sys_int_en), .resume_pc(resume_pc), .pipe_busy(pipe_busy),
    .pc_stop(a_stop), .flush(a_flush), .interrupt_ask(a_ask), .interrupt_pc(a_pc),
    .interrupt_ipc(a_ipc), .irq_ack(a_ack), .irq_fault(a_fault));

  irq_entry_ctrl #(.VEC_BASE(BASE_W), .DRAIN_LIMIT(LIM_A)) dut_w (
    .clk(clk), .all_rst_n(all_rst_n), .irq_req(irq_req), .irq_num(irq_num),
    .sys_int_en(sys_int_en), .resume_pc(resume_pc), .pipe_busy(pipe_busy),
    .pc_stop(w_stop), .flush(w_flush), .interrupt_ask(w_ask), .interrupt_pc(w_pc),
    .interrupt_ipc(w_ipc), .irq_ack(w_ack), .irq_fault(w_fault));

  irq_entry_ctrl #(.VEC_BASE(BASE_A), .DRAIN_LIMIT(LIM_T)) dut_t (
    .clk(clk), .all_rst_n(all_rst_n), .irq_req(irq_req), .irq_num(irq_num),
    .sys_int_en(sys_int_en), .resume_pc(resume_pc), .pipe_busy(pipe_busy),
    .pc_stop(t_stop), .flush(t_flush), .interrupt_ask(t_ask), .interrupt_pc(t_pc),
    .interrupt_ipc(t_ipc), .irq_ack(t_ack), .irq_fault(t_fault));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Timeline model of dut_a: m_t counts cycles since the request was taken
  // (HOLD is 1, drain starts at 2); m_enter is the ENTER cycle once known.
  bit          m_active = 1'b0;
  int          m_t      = 0;
  int          m_enter  = -1;
  logic [7:0]  m_num    = '0;
  logic [31:0] m_ipc    = '0;
  bit          m_fault  = 1'b0;

  task automatic model_step();
    if (!all_rst_n) begin
      m_active = 1'b0;
      m_fault  = 1'b0;
    end else if (!m_active) begin
      if (irq_req && sys_int_en) begin
        m_active = 1'b1;
        m_t      = 1;
        m_enter  = -1;
        m_num    = irq_num;
        m_ipc    = resume_pc;
      end
    end else begin
      if (m_t >= 2 && m_enter < 0) begin
        if (!pipe_busy) m_enter = m_t + 1;
`ifdef IRQ_DRAIN_TIMEOUT_EN
        else if (m_t - 1 == LIM_A) begin
          m_enter = m_t + 1;
          m_fault = 1'b1;
        end
`endif
      end
      m_t++;
      if (m_enter >= 0 && m_t > m_enter + 1) m_active = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [7:0]  num;
    logic        en;
    logic [31:0] rpc;
    logic        busy;
    logic        e_stop;
    logic        e_flush;
    logic        e_ask;
    logic [31:0] e_pc;
    logic [31:0] e_pcw;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic req, logic [7:0] num, logic en, logic [31:0] rpc,
                              logic stp, logic fl, logic ask,
                              logic [31:0] pc, logic [31:0] pcw, logic [31:0] ipc);
    vec_t v;
    v.req = req; v.num = num; v.en = en; v.rpc = rpc; v.busy = 1'b0;
    v.e_stop = stp; v.e_flush = fl; v.e_ask = ask;
    v.e_pc = pc; v.e_pcw = pcw; v.e_ipc = ipc;
    return v;
  endfunction

  task automatic set_in(logic req, logic [7:0] num, logic en, logic [31:0] rpc, logic busy);
    irq_req = req; irq_num = num; sys_int_en = en; resume_pc = rpc; pipe_busy = busy;
  endtask

  logic        x_stop, x_flush, x_ask;
  logic [31:0] x_pc, x_pcw, x_ipc;

  initial begin
    all_rst_n = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);

    // Reset state
    tick(); tick();
    chk("rst_pc_stop", 0, a_stop, 0);
    chk("rst_flush", 0, a_flush, 0);
    chk("rst_ask", 0, a_ask, 0);
    chk("rst_ack", 0, a_ack, 0);
    chk("rst_ipc", 0, a_ipc, 0);
    chk("rst_pc", 0, a_pc, 0);
    chk("rst_fault", 0, t_fault, 0);
    all_rst_n = 1'b1;
    tick();

    // Row k drives edge k; expected values are the outputs of cycle k+1.
    tbl[0]  = mk(1, 8'h05, 1, 32'h00010040, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 8'h05, 1, 32'h00010040, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 8'h05, 1, 32'h00010040, 1, 0, 1, 32'h00000114, 32'hFFFFFF14, 32'h00010040);
    tbl[3]  = mk(0, 8'h05, 0, 32'h00010040, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 8'h05, 0, 32'h00010040, 0, 0, 0, 0, 0, 0);
    for (int i = 5; i < 10; i++)
      tbl[i] = mk(1, 8'h05, 0, 32'h00010040, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 8'hFF, 1, 32'h00020000, 1, 1, 0, 0, 0, 0);
    tbl[11] = mk(1, 8'hFF, 1, 32'h00020000, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 8'hFF, 1, 32'h00020000, 1, 0, 1, 32'h000004FC, 32'h000002FC, 32'h00020000);
    tbl[13] = mk(0, 8'hFF, 0, 32'h00020000, 0, 1, 0, 0, 0, 0);
    tbl[14] = mk(0, 8'hFF, 0, 32'h00020000, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].req, tbl[i].num, tbl[i].en, tbl[i].rpc, tbl[i].busy);
      tick();
      chk("tbl_pc_stop", i, a_stop, tbl[i].e_stop);
      chk("tbl_flush", i, a_flush, tbl[i].e_flush);
      chk("tbl_ask", i, a_ask, tbl[i].e_ask);
      chk("tbl_ack", i, a_ack, tbl[i].e_ask);
      chk("tbl_pc", i, a_pc, tbl[i].e_pc);
      chk("tbl_pc_wrap", i, w_pc, tbl[i].e_pcw);
      chk("tbl_ipc", i, a_ipc, tbl[i].e_ipc);
    end

    // pipe_busy high in DRAIN cycles 2..6; resume_pc changes after capture.
    set_in(1'b1, 8'h05, 1'b1, 32'h00010040, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("busy_ask", c, a_ask, (c == 8) ? 1 : 0);
      chk("busy_pc_stop", c, a_stop, (c <= 8) ? 1 : 0);
      chk("busy_flush", c, a_flush, (c == 1 || c == 9) ? 1 : 0);
      chk("busy_ipc", c, a_ipc, (c == 8) ? 32'h00010040 : 32'h0);
      resume_pc  = 32'hDEAD0000;
      pipe_busy  = (c >= 2 && c <= 6);
      irq_req    = (c < 8);
      sys_int_en = (c < 8);
    end

    // Reset asserted while in DRAIN
    set_in(1'b1, 8'h05, 1'b1, 32'h00010040, 1'b1);
    tick(); tick();
    chk("mid_pc_stop_before", 0, a_stop, 1);
    all_rst_n = 1'b0;
    tick();
    chk("mid_pc_stop", 0, a_stop, 0);
    chk("mid_flush", 0, a_flush, 0);
    chk("mid_ask", 0, a_ask, 0);
    chk("mid_ack", 0, a_ack, 0);
    chk("mid_pc", 0, a_pc, 0);
    chk("mid_ipc", 0, a_ipc, 0);
    all_rst_n = 1'b1;
    set_in(1'b0, 8'h05, 1'b0, 32'h00010040, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_no_ask", c, a_ask, 0);
      chk("mid_no_stop", c, a_stop, 0);
    end

    // Drain with pipe_busy held high on the DRAIN_LIMIT=4 instance
    set_in(1'b1, 8'h05, 1'b1, 32'h00010040, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      tick();
`ifdef IRQ_DRAIN_TIMEOUT_EN
      chk("tmo_ask", c, t_ask, (c == 6) ? 1 : 0);
      chk("tmo_fault", c, t_fault, (c >= 6) ? 1 : 0);
      chk("tmo_pc_stop", c, t_stop, (c <= 6) ? 1 : 0);
`else
      chk("hold_ask", c, t_ask, 0);
      chk("hold_fault", c, t_fault, 0);
      chk("hold_pc_stop", c, t_stop, 1);
`endif
      irq_req    = 1'b0;
      sys_int_en = 1'b0;
    end
    all_rst_n = 1'b0;
    tick();
    chk("tmo_fault_rst", 0, t_fault, 0);
    chk("tmo_stop_rst", 0, t_stop, 0);
    all_rst_n = 1'b1;
    pipe_busy = 1'b0;
    tick();

    // Randomized run against the timeline model
    for (int n = 0; n < 3000; n++) begin
      all_rst_n  = ($urandom_range(0, 199) != 0);
      irq_req    = ($urandom_range(0, 2) != 0);
      sys_int_en = $urandom_range(0, 1);
      irq_num    = 8'($urandom);
      resume_pc  = $urandom;
      pipe_busy  = ($urandom_range(0, 3) != 0);
      tick();
      x_stop  = m_active && (m_enter < 0 || m_t <= m_enter);
      x_flush = m_active && (m_t == 1 || (m_enter >= 0 && m_t == m_enter + 1));
      x_ask   = m_active && m_enter >= 0 && m_t == m_enter;
      x_pc    = x_ask ? BASE_A + {22'b0, m_num, 2'b00} : 32'h0;
      x_pcw   = x_ask ? BASE_W + 32'(m_num) * 32'd4 : 32'h0;
      x_ipc   = x_ask ? m_ipc : 32'h0;
      chk("rnd_pc_stop", n, a_stop, x_stop);
      chk("rnd_flush", n, a_flush, x_flush);
      chk("rnd_ask", n, a_ask, x_ask);
      chk("rnd_ack", n, a_ack, x_ask);
      chk("rnd_pc", n, a_pc, x_pc);
      chk("rnd_pc_wrap", n, w_pc, x_pcw);
      chk("rnd_ipc", n, a_ipc, x_ipc);
      chk("rnd_fault", n, a_fault, m_fault);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_entry_ctrl.md
# irq_entry_ctrl

Interrupt entry sequencer in front of the register group's interrupt port. It accepts an 8-bit interrupt request and freezes instruction fetch. It waits for in-flight writebacks to drain, then issues the single-cycle `interrupt_ask` with the vector PC and resume PC. It sits between the external interrupt source, the fetch/load-order stage, and the register group.

## Interface
Parameters:
- `VEC_BASE`, default `32'h00000100`: base address of the vector table.
- `DRAIN_LIMIT`, default 64: maximum number of drain cycles; used only with `IRQ_DRAIN_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `all_rst_n`  in  1  synchronous reset, active-low.
- `irq_req`  in  1  level interrupt request.
- `irq_num`  in  8  interrupt number; sampled with `irq_req`.
- `sys_int_en`  in  1  interrupt-enable bit taken from the `sys` register.
- `resume_pc`  in  32  address of the oldest uncommitted instruction.
- `pipe_busy`  in  1  high while any writeback is still pending.
- `pc_stop`  out  1  freezes `pc` update in the register group.
- `flush`  out  1  kills fetched, non-committed instructions.
- `interrupt_ask`  out  1  one-cycle entry strobe to the register group.
- `interrupt_pc`  out  32  vector address.
- `interrupt_ipc`  out  32  latched resume address.
- `irq_ack`  out  1  one-cycle acknowledge to the source.
- `irq_fault`  out  1  sticky drain-timeout flag; always 0 unless `IRQ_DRAIN_TIMEOUT_EN` is defined.

## Operation
- FSM states: IDLE, HOLD, DRAIN, ENTER, SETTLE.
- IDLE:
  - If `irq_req && sys_int_en`: latch `irq_num` into `num_q` and `resume_pc` into `ipc_q`, then go to HOLD.
  - Otherwise stay in IDLE.
- HOLD: assert `pc_stop` and `flush`; go to DRAIN unconditionally.
- DRAIN:
  - Assert `pc_stop`.
  - Go to ENTER on the first cycle with `pipe_busy == 0`.
  - DRAIN always lasts at least 1 cycle.
- ENTER:
  - Assert `pc_stop`, `interrupt_ask` and `irq_ack` for exactly 1 cycle.
  - Drive `interrupt_pc = VEC_BASE + {22'b0, num_q, 2'b00}`, computed modulo 2^32; wrap-around is allowed and not flagged.
  - Drive `interrupt_ipc = ipc_q`.
  - Go to SETTLE.
- SETTLE:
  - Assert `flush` for 1 cycle so the stale fetch is discarded; `pc_stop` is deasserted.
  - Go to IDLE.
  - `sys` has been cleared by the register group, so the request that was just taken cannot re-trigger until software re-enables interrupts.
- Outside ENTER: `interrupt_pc` and `interrupt_ipc` drive 0 and are don't-care to consumers.
- Input sampling:
  - `irq_req`, `irq_num` and `resume_pc` are ignored in every state other than IDLE.
  - A source that holds `irq_req` high keeps its request until `irq_ack`.
  - `sys_int_en` going low after the request is latched does not abort the sequence.
- Reset:
  - `all_rst_n == 0` on any edge forces IDLE, clears `num_q`, `ipc_q`, the drain counter and `irq_fault`.
  - All outputs read 0 on the following cycle, including mid-sequence (for example during DRAIN).

## Timing
- Reset value of every output: 0.
- Cycle numbering:
  - Request sampled at edge 0; HOLD occupies cycle 1.
  - With `pipe_busy` low: DRAIN is cycle 2, ENTER is cycle 3, SETTLE is cycle 4.
  - Minimum request-to-`interrupt_ask` latency is therefore 3 cycles.
- Each cycle of `pipe_busy` high in DRAIN adds 1 cycle of latency.
- `pc_stop` is continuously high from HOLD through ENTER (3 cycles minimum).
- `flush` is high in HOLD and in SETTLE only.
- `interrupt_ask` and `irq_ack` are coincident and never longer than 1 cycle.
- Earliest next acceptance is in the cycle after SETTLE.

## Configuration
- `IRQ_DRAIN_TIMEOUT_EN` defined:
  - A counter increments each DRAIN cycle.
  - If it reaches `DRAIN_LIMIT` with `pipe_busy` still high, go to ENTER anyway and set `irq_fault` (sticky until reset).
  - The counter clears on entering DRAIN.
- `IRQ_DRAIN_TIMEOUT_EN` undefined:
  - DRAIN waits indefinitely.
  - No counter is built; `irq_fault` is tied 0.

## Test plan
- Reset release, then `irq_req=1`, `irq_num=8'h05`, `sys_int_en=1`, `resume_pc=32'h00010040`, `pipe_busy=0`:
  - `interrupt_ask` high in cycle 3 only.
  - `interrupt_pc=32'h00000114`, `interrupt_ipc=32'h00010040`.
  - `pc_stop` high in cycles 1–3; `flush` high in cycles 1 and 4.
- Same request with `sys_int_en=0`: no output ever leaves 0.
- `pipe_busy` high for 5 cycles after HOLD:
  - `interrupt_ask` in cycle 8.
  - `resume_pc` changing to `32'hDEAD0000` during DRAIN is not reflected; `interrupt_ipc` stays `32'h00010040`.
- `VEC_BASE=32'hFFFFFF00`, `irq_num=8'hFF`: `interrupt_pc=32'h000002FC` (wrap-around).
- `all_rst_n` pulled low during DRAIN: all outputs 0 on the next cycle, and no `interrupt_ask` follows.
- With `IRQ_DRAIN_TIMEOUT_EN`, `DRAIN_LIMIT=4`, `pipe_busy` held high: `interrupt_ask` in cycle 6 and `irq_fault=1` until reset.
